register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
Parametrised successor to the single-port register file. It has two independent read ports and one write port, with registered outputs. Optional write-to-read bypass and an optional hardwired zero register are selected by parameter. A hardware clear sequencer initialises every entry after reset and on request, so the array itself needs no reset and still infers as RAM/LUT storage. It is the operand store for the datapath, which reads two operands per cycle.

Parameters:
REG_BITS, 8, width of each register in bits
ADDR_BITS, 3, address width; depth = 2**ADDR_BITS entries
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read port; 0 = read returns the old contents
ZERO_REG, 0, 1 = entry 0 always reads as 0 and writes to it are silently discarded
CLEAR_VAL, 0, REG_BITS-wide value written to every entry by the clear sequencer

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request
wr_addr  input  ADDR_BITS  write address
wr_data  input  REG_BITS  write data
r_addr_a  input  ADDR_BITS  read port A address
r_addr_b  input  ADDR_BITS  read port B address
clr_start  input  1  request a full clear sweep (single-cycle pulse)
r_data_a  output  REG_BITS  read port A data, registered
r_data_b  output  REG_BITS  read port B data, registered
busy  output  1  clear sweep in progress; writes are refused
wr_err  output  1  one-cycle pulse: the previous cycle's write was refused

Behaviour:
- Reset values (asserted asynchronously): r_data_a = r_data_b = 0, wr_err = 0, busy = 1, state = CLEAR, sweep counter = 0. Array contents are not reset.
- State machine has two states, IDLE and CLEAR.
- CLEAR state:
  - Each cycle, write CLEAR_VAL to entry[counter], then increment counter.
  - After the cycle that writes entry 2**ADDR_BITS-1, go to IDLE. busy is low from the next cycle.
  - A sweep lasts exactly 2**ADDR_BITS cycles.
- CLEAR is therefore entered automatically after every reset release.
- IDLE state: clr_start=1 moves to CLEAR with counter=0, and busy=1 the next cycle. clr_start is ignored while busy.
- Write (IDLE only): wr_en=1 writes wr_data to entry[wr_addr] at the edge. The write is visible to a read issued in the next cycle.
- Write in the same cycle as an accepted clr_start: the write is performed, and the sweep will later overwrite it.
- Write while busy: the write is discarded, and wr_err=1 for exactly the next cycle. wr_err is otherwise 0.
- ZERO_REG=1 and wr_addr=0: the write is discarded, with no wr_err.
- Reads:
  - Latency is 1 cycle: r_data_x after edge n = entry[r_addr_x] sampled at edge n.
  - The two ports are fully independent. Both ports may use the same address, and both return the same value.
- Bypass (BYPASS=1): if an accepted write in the same cycle matches r_addr_x, r_data_x = wr_data. With BYPASS=0, r_data_x = the pre-write contents.
- Bypass never applies to a refused write or to a discarded write to entry 0.
- ZERO_REG=1: a read of address 0 yields 0 regardless of contents or bypass.
- While busy, both read ports register CLEAR_VAL, independent of address. Exception: ZERO_REG=1 with address 0 still yields 0.
- Reset asserted mid-sweep or mid-operation: immediate return to the reset values. The sweep restarts from entry 0 after release.
- All address arithmetic is unsigned. The sweep counter is ADDR_BITS+1 bits wide or uses terminal-compare, so it never wraps to re-enter entry 0.

Test Plan:
- Reset released, defaults (ADDR_BITS=3, CLEAR_VAL=8'hA5) -> busy=1 for exactly 8 cycles, then 0; afterwards a read of every address returns 8'hA5 on both ports.
- IDLE, write 8'h3C to addr 5, next cycle r_addr_a=5, r_addr_b=5 -> both r_data = 8'h3C one cycle later.
- BYPASS=1, same cycle wr_en=1 addr 2 data 8'h77 and r_addr_a=2 -> r_data_a=8'h77 next cycle; repeat with BYPASS=0 -> the old value (8'hA5).
- clr_start pulse, then wr_en=1 during cycle 3 of the sweep -> busy=1 for 8 cycles, wr_err=1 for one cycle, the written entry reads CLEAR_VAL afterwards, and reads during the sweep return CLEAR_VAL.
- ZERO_REG=1, write 8'hFF to addr 0 -> r_data at addr 0 = 0 (with and without bypass), wr_err stays 0.
- Assert reset at sweep cycle 4 for 2 cycles -> outputs return to reset values immediately; after release busy=1 for a full 8 cycles.

Source files
------------

// File: rtl/register_file_2r1w.sv
// Two-read / one-write register file with registered read ports and a hardware clear sweep.
// Latency: reads return data one cycle after the address is presented; writes are visible to the next cycle's read.
// Backpressure: while a clear sweep runs (busy=1), writes are refused and flagged on wr_err the following cycle.
module register_file_2r1w #(
    parameter int                  REG_BITS  = 8,
    parameter int                  ADDR_BITS = 3,
    parameter int                  BYPASS    = 1,
    parameter int                  ZERO_REG  = 0,
    parameter logic [REG_BITS-1:0] CLEAR_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [REG_BITS-1:0]  wr_data,
    input  logic [ADDR_BITS-1:0] r_addr_a,
    input  logic [ADDR_BITS-1:0] r_addr_b,
    input  logic                 clr_start,
    output logic [REG_BITS-1:0]  r_data_a,
    output logic [REG_BITS-1:0]  r_data_b,
    output logic                 busy,
    output logic                 wr_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {IDLE, CLEAR} state_t;

    // Storage array deliberately has no reset so it maps onto RAM/LUT storage.
    logic [REG_BITS-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  wr_err_q, wr_err_d;
    logic [REG_BITS-1:0]   rd_a_q, rd_a_d;
    logic [REG_BITS-1:0]   rd_b_q, rd_b_d;

    logic                  wr_zero;
    logic                  wr_accept;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [REG_BITS-1:0]   mem_wdata;

    // A user write lands only when idle and not aimed at a hardwired-zero entry 0.
    assign wr_zero   = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_accept = wr_en && !busy_q && !wr_zero;

    // Single physical write port: the sweep owns it while busy, the user otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (busy_q) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = CLEAR_VAL;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    // Array write; no reset so the storage stays a plain memory.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Sweep control and read-port next-state selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_err_d = wr_en && busy_q;

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                // Terminal compare on the last entry keeps the counter from re-entering entry 0.
                if (&cnt_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        busy_d = (state_d == CLEAR);

        if ((ZERO_REG != 0) && (r_addr_a == '0)) begin
            rd_a_d = '0;
        end else if (busy_q) begin
            rd_a_d = CLEAR_VAL;
        end else if ((BYPASS != 0) && wr_accept && (wr_addr == r_addr_a)) begin
            rd_a_d = wr_data;
        end else begin
            rd_a_d = mem[r_addr_a];
        end

        if ((ZERO_REG != 0) && (r_addr_b == '0)) begin
            rd_b_d = '0;
        end else if (busy_q) begin
            rd_b_d = CLEAR_VAL;
        end else if ((BYPASS != 0) && wr_accept && (wr_addr == r_addr_b)) begin
            rd_b_d = wr_data;
        end else begin
            rd_b_d = mem[r_addr_b];
        end
    end

    // Control state and registered outputs; reset starts a fresh sweep from entry 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            wr_err_q <= 1'b0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            wr_err_q <= wr_err_d;
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
        end
    end

    assign r_data_a = rd_a_q;
    assign r_data_b = rd_b_q;
    assign busy     = busy_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench: four parameter variants share one stimulus stream.
// Variants: b1 (bypass), b0 (no bypass), z (bypass + zero reg), z0 (zero reg, no bypass).
// All variants clear to 8'hA5.
module tb_register_file_2r1w;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] r_addr_a, r_addr_b;
    logic       clr_start;

    logic [7:0] rda1, rdb1, rda0, rdb0, rdaz, rdbz, rdaz0, rdbz0;
    logic       busy1, busy0, busyz, busyz0;
    logic       err1, err0, errz, errz0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file_2r1w #(.REG_BITS(8), .ADDR_BITS(3), .BYPASS(1), .ZERO_REG(0), .CLEAR_VAL(8'hA5)) dut_b1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .clr_start(clr_start),
        .r_data_a(rda1), .r_data_b(rdb1), .busy(busy1), .wr_err(err1));

    register_file_2r1w #(.REG_BITS(8), .ADDR_BITS(3), .BYPASS(0), .ZERO_REG(0), .CLEAR_VAL(8'hA5)) dut_b0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .clr_start(clr_start),
        .r_data_a(rda0), .r_data_b(rdb0), .busy(busy0), .wr_err(err0));

    register_file_2r1w #(.REG_BITS(8), .ADDR_BITS(3), .BYPASS(1), .ZERO_REG(1), .CLEAR_VAL(8'hA5)) dut_z (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .clr_start(clr_start),
        .r_data_a(rdaz), .r_data_b(rdbz), .busy(busyz), .wr_err(errz));

    register_file_2r1w #(.REG_BITS(8), .ADDR_BITS(3), .BYPASS(0), .ZERO_REG(1), .CLEAR_VAL(8'hA5)) dut_z0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .clr_start(clr_start),
        .r_data_a(rdaz0), .r_data_b(rdbz0), .busy(busyz0), .wr_err(errz0));

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] a1;   // dut_b1 r_data_a
        logic [7:0] b1;   // dut_b1 r_data_b
        logic [7:0] a0;   // dut_b0 r_data_a
        logic [7:0] az;   // dut_z  r_data_a
        logic [7:0] az0;  // dut_z0 r_data_a
    } vec_t;

    vec_t vt [8];

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // After the first sweep every entry holds A5; the table then walks writes/reads in IDLE.
        vt[0] = '{1'b1, 3'd5, 8'h3C, 3'd1, 3'd2, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        vt[1] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        vt[2] = '{1'b1, 3'd2, 8'h77, 3'd2, 3'd5, 8'h77, 8'h3C, 8'hA5, 8'h77, 8'hA5};
        vt[3] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77};
        vt[4] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 8'hFF, 8'hFF, 8'hA5, 8'h00, 8'h00};
        vt[5] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd5, 8'hFF, 8'h3C, 8'hFF, 8'h00, 8'h00};
        vt[6] = '{1'b1, 3'd7, 8'h01, 3'd6, 3'd7, 8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5};
        vt[7] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd0, 8'h01, 8'hFF, 8'h01, 8'h01, 8'h01};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        r_addr_a = 3'd3; r_addr_b = 3'd0; clr_start = 1'b0;

        // Reset values
        tick(); tick();
        chk8("rst_rda", rda1, 8'h00);
        chk8("rst_rdb", rdb1, 8'h00);
        chk1("rst_busy", busy1, 1'b1);
        chk1("rst_err", err1, 1'b0);

        // Initial sweep: busy for exactly 8 cycles, reads return CLEAR_VAL
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk1("init_busy", busy1, (k < 8));
            chk8("init_sweep_rda", rda1, 8'hA5);
            chk8("init_sweep_zero", rdbz, 8'h00);
        end

        // Every entry reads A5 on both ports (zero-reg variants read 0 at address 0)
        for (int i = 0; i < 8; i++) begin
            r_addr_a = 3'(i);
            r_addr_b = 3'(7 - i);
            tick();
            chk8("all_a_b1", rda1, 8'hA5);
            chk8("all_b_b1", rdb1, 8'hA5);
            chk8("all_a_b0", rda0, 8'hA5);
            chk8("all_b_b0", rdb0, 8'hA5);
            chk8("all_a_z", rdaz, (i == 0) ? 8'h00 : 8'hA5);
            chk8("all_b_z", rdbz, (i == 7) ? 8'h00 : 8'hA5);
            chk8("all_b_z0", rdbz0, (i == 7) ? 8'h00 : 8'hA5);
        end

        // Table: writes, next-cycle visibility, bypass on/off, zero register
        for (int v = 0; v < 8; v++) begin
            wr_en = vt[v].we; wr_addr = vt[v].wa; wr_data = vt[v].wd;
            r_addr_a = vt[v].ra; r_addr_b = vt[v].rb;
            tick();
            chk8("vec_a_b1", rda1, vt[v].a1);
            chk8("vec_b_b1", rdb1, vt[v].b1);
            chk8("vec_a_b0", rda0, vt[v].a0);
            chk8("vec_a_z", rdaz, vt[v].az);
            chk8("vec_a_z0", rdaz0, vt[v].az0);
            chk1("vec_busy", busy1 | busy0 | busyz | busyz0, 1'b0);
            chk1("vec_err", err1 | err0 | errz | errz0, 1'b0);
        end
        wr_en = 1'b0;

        // Requested sweep: refused write in sweep cycle 3, repeated clr_start ignored
        r_addr_a = 3'd4; r_addr_b = 3'd0;
        clr_start = 1'b1;
        tick();
        chk1("clr_busy0", busy1, 1'b1);
        clr_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wr_en = (k == 2); wr_addr = 3'd4; wr_data = 8'hEE;
            clr_start = (k == 5);
            tick();
            chk1("clr_busy", busy1, (k < 7));
            chk1("clr_err", err1, (k == 2));
            chk8("clr_rda", rda1, 8'hA5);
            chk8("clr_zero_rdb", rdbz, 8'h00);
        end
        wr_en = 1'b0; clr_start = 1'b0;
        tick();
        chk1("clr_err_after", err1, 1'b0);
        r_addr_a = 3'd4; r_addr_b = 3'd7;
        tick();
        chk8("clr_entry4", rda1, 8'hA5);
        chk8("clr_entry7", rdb1, 8'hA5);
        r_addr_a = 3'd0;
        tick();
        chk8("clr_entry0", rda1, 8'hA5);

        // Reset during sweep cycle 4
        r_addr_a = 3'd2; r_addr_b = 3'd5;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_en = (k == 3); wr_addr = 3'd1; wr_data = 8'h11;
            tick();
        end
        wr_en = 1'b0;
        chk1("mid_err_pre", err1, 1'b1);
        chk8("mid_rda_pre", rda1, 8'hA5);
        reset = 1'b1;
        #1;
        chk8("mid_rst_rda", rda1, 8'h00);
        chk8("mid_rst_rdb", rdb1, 8'h00);
        chk1("mid_rst_busy", busy1, 1'b1);
        chk1("mid_rst_err", err1, 1'b0);
        tick(); tick();
        chk8("mid_hold_rda", rda1, 8'h00);
        chk1("mid_hold_busy", busy1, 1'b1);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk1("mid_busy", busy1, (k < 8));
        end
        r_addr_a = 3'd1; r_addr_b = 3'd2;
        tick();
        chk8("mid_entry1", rda1, 8'hA5);
        chk8("mid_entry2", rdb1, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
